pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 137 +++++++++++++
 tb/tb_pc_gen.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
`default_nettype none
// pc_gen: fetch PC generator with trap/redirect/stall handling and an optional PC trace buffer.
// Optional trace buffer enabled by defining macro PC_TRACE_EN; rev 1.0.

module pc_gen #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC    = WIDTH'(32'h0000_0100),
  parameter int               INC         = 4,
  parameter int               TRACE_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         trap_valid,
  output logic [WIDTH-1:0]             pc,
  output logic                         pc_valid,
  output logic                         misalign_err,
  input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
  output logic [WIDTH-1:0]             trace_pc,
  output logic [$clog2(TRACE_DEPTH):0] trace_count
);

  localparam int IDXW = $clog2(TRACE_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] pc_next;
  logic             pc_valid_next;
  logic             misalign_next;
  logic [WIDTH-1:0] redirect_aligned;

  assign redirect_aligned = {redirect_target[WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_VEC;
      pc_valid     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_next;
      pc           <= pc_next;
      pc_valid     <= pc_valid_next;
      misalign_err <= misalign_next;
    end
  end

  // RUN and BUBBLE share trap/redirect handling; only the fall-through differs.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    pc_valid_next = pc_valid;
    misalign_next = 1'b0;
    case (state)
      IDLE: begin
        state_next    = RUN;
        pc_valid_next = 1'b1;
      end
      RUN, BUBBLE: begin
        if (trap_valid) begin
          pc_next       = TRAP_VEC;
          pc_valid_next = 1'b0;
          state_next    = BUBBLE;
        end else if (redirect_valid) begin
          pc_next       = redirect_aligned;
          pc_valid_next = 1'b0;
          state_next    = BUBBLE;
          misalign_next = |redirect_target[1:0];
        end else if (state == BUBBLE) begin
          pc_valid_next = 1'b1;
          state_next    = RUN;
        end else if (!stall) begin
          pc_next = pc + WIDTH'(INC);
        end
      end
      default: begin
        state_next    = IDLE;
        pc_valid_next = 1'b0;
      end
    endcase
  end

`ifdef PC_TRACE_EN
  generate
    if (1) begin : g_trace
      logic [WIDTH-1:0] trace_mem [TRACE_DEPTH];
      logic [IDXW-1:0]  wptr;
      logic [IDXW-1:0]  rptr;
      logic [IDXW:0]    count;
      logic             trace_we;

      assign trace_we = (state == RUN) && pc_valid && !stall &&
                        !trap_valid && !redirect_valid;

      always_ff @(posedge clk) begin
        if (rst) begin
          wptr  <= '0;
          count <= '0;
        end else if (trace_we) begin
          wptr <= wptr + IDXW'(1);
          if (count != (IDXW+1)'(TRACE_DEPTH)) begin
            count <= count + (IDXW+1)'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!rst && trace_we) begin
          trace_mem[wptr] <= pc;
        end
      end

      // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
      assign rptr        = wptr - IDXW'(1) - trace_idx;
      assign trace_pc    = ({1'b0, trace_idx} < count) ? trace_mem[rptr] : '0;
      assign trace_count = count;
    end
  endgenerate
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_pc         = '0;
  assign trace_count      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// tb_pc_gen: directed self-checking bench for pc_gen (32-bit instance plus an 8-bit wrap instance).

module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid, trap_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc, trace_pc;
  logic        pc_valid, misalign_err;
  logic [2:0]  trace_idx;
  logic [3:0]  trace_count;

  logic        rst8, stall8, redir8, trap8;
  logic [7:0]  target8, pc8, trace_pc8;
  logic        pc_valid8, misalign8;
  logic [2:0]  trace_idx8;
  logic [3:0]  trace_count8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap_valid(trap_valid), .pc(pc),
    .pc_valid(pc_valid), .misalign_err(misalign_err), .trace_idx(trace_idx),
    .trace_pc(trace_pc), .trace_count(trace_count)
  );

  pc_gen #(.WIDTH(8), .RESET_VEC(8'hF0), .TRAP_VEC(8'h40)) dut8 (
    .clk(clk), .rst(rst8), .stall(stall8), .redirect_valid(redir8),
    .redirect_target(target8), .trap_valid(trap8), .pc(pc8),
    .pc_valid(pc_valid8), .misalign_err(misalign8), .trace_idx(trace_idx8),
    .trace_pc(trace_pc8), .trace_count(trace_count8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; trap_valid = 1'b0;
    redirect_target = '0; trace_idx = '0;
    tick(); tick();
    tests++; if (pc !== 32'h0) begin fails++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0); end
    tests++; if (pc_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", pc_valid); end
    tests++; if (misalign_err !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b exp 0", misalign_err); end
    tests++; if (trace_count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", trace_count); end
  endtask

  task automatic test_startup();
    logic [31:0] exp_pc [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (pc !== exp_pc[i] || pc_valid !== 1'b1) begin
        fails++; $display("FAIL startup_%0d got pc=%h v=%b exp pc=%h v=1", i, pc, pc_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_redirect();
    tick();
    tests++; if (pc !== 32'h10) begin fails++; $display("FAIL redir_pre got %h exp 10", pc); end
    redirect_valid = 1'b1; redirect_target = 32'h203;
    tick();
    redirect_valid = 1'b0;
    tests++; if (pc !== 32'h200 || pc_valid !== 1'b0 || misalign_err !== 1'b1) begin
      fails++; $display("FAIL redir_bubble got pc=%h v=%b m=%b exp pc=200 v=0 m=1", pc, pc_valid, misalign_err);
    end
    tick();
    tests++; if (pc !== 32'h200 || pc_valid !== 1'b1 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL redir_first got pc=%h v=%b m=%b exp pc=200 v=1 m=0", pc, pc_valid, misalign_err);
    end
    tick();
    tests++; if (pc !== 32'h204 || pc_valid !== 1'b1) begin
      fails++; $display("FAIL redir_next got pc=%h v=%b exp pc=204 v=1", pc, pc_valid);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      tests++; if (pc !== 32'h204 || pc_valid !== 1'b1) begin
        fails++; $display("FAIL stall_hold_%0d got pc=%h v=%b exp pc=204 v=1", i, pc, pc_valid);
      end
    end
  endtask

  task automatic test_trap_priority();
    trap_valid = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h303;
    tick();
    trap_valid = 1'b0; redirect_valid = 1'b0;
    tests++; if (pc !== 32'h100 || pc_valid !== 1'b0 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL trap_prio got pc=%h v=%b m=%b exp pc=100 v=0 m=0", pc, pc_valid, misalign_err);
    end
    tick();
    tests++; if (pc !== 32'h100 || pc_valid !== 1'b1) begin
      fails++; $display("FAIL trap_bubble_exit got pc=%h v=%b exp pc=100 v=1", pc, pc_valid);
    end
    stall = 1'b0;
    tick();
    tests++; if (pc !== 32'h104) begin fails++; $display("FAIL trap_run got %h exp 104", pc); end
  endtask

  task automatic test_bubble_redirect();
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    tests++; if (pc !== 32'h40 || pc_valid !== 1'b0 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL bub_first got pc=%h v=%b m=%b exp pc=40 v=0 m=0", pc, pc_valid, misalign_err);
    end
    redirect_target = 32'h52;
    tick();
    redirect_valid = 1'b0;
    tests++; if (pc !== 32'h50 || pc_valid !== 1'b0 || misalign_err !== 1'b1) begin
      fails++; $display("FAIL bub_second got pc=%h v=%b m=%b exp pc=50 v=0 m=1", pc, pc_valid, misalign_err);
    end
    tick();
    tests++; if (pc !== 32'h50 || pc_valid !== 1'b1 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL bub_exit got pc=%h v=%b m=%b exp pc=50 v=1 m=0", pc, pc_valid, misalign_err);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] exp_pc [5] = '{8'hF0, 8'hF4, 8'hF8, 8'hFC, 8'h00};
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++; if (pc8 !== exp_pc[i] || pc_valid8 !== 1'b1) begin
        fails++; $display("FAIL wrap_%0d got pc=%h v=%b exp pc=%h v=1", i, pc8, pc_valid8, exp_pc[i]);
      end
    end
  endtask

  task automatic test_trace();
    rst = 1'b1; tick();
    rst = 1'b0; tick();
    for (int i = 0; i < 10; i++) tick();
    tests++; if (pc !== 32'h28) begin fails++; $display("FAIL trace_pc_after got %h exp 28", pc); end
`ifdef PC_TRACE_EN
    tests++; if (trace_count !== 4'd8) begin fails++; $display("FAIL trace_count got %0d exp 8", trace_count); end
    trace_idx = 3'd0; #1;
    tests++; if (trace_pc !== 32'h24) begin fails++; $display("FAIL trace_idx0 got %h exp 24", trace_pc); end
    trace_idx = 3'd1; #1;
    tests++; if (trace_pc !== 32'h20) begin fails++; $display("FAIL trace_idx1 got %h exp 20", trace_pc); end
    trace_idx = 3'd7; #1;
    tests++; if (trace_pc !== 32'h08) begin fails++; $display("FAIL trace_idx7 got %h exp 08", trace_pc); end
`else
    tests++; if (trace_count !== 4'd0) begin fails++; $display("FAIL trace_count_off got %0d exp 0", trace_count); end
    trace_idx = 3'd0; #1;
    tests++; if (trace_pc !== 32'h0) begin fails++; $display("FAIL trace_pc_off got %h exp 0", trace_pc); end
`endif
    trace_idx = 3'd0;
  endtask

  task automatic test_reset_bubble();
    redirect_valid = 1'b1; redirect_target = 32'h80;
    tick();
    tests++; if (pc !== 32'h80 || pc_valid !== 1'b0) begin
      fails++; $display("FAIL rstbub_pre got pc=%h v=%b exp pc=80 v=0", pc, pc_valid);
    end
    rst = 1'b1; redirect_target = 32'h83;
    tick();
    redirect_valid = 1'b0;
    tests++; if (pc !== 32'h0 || pc_valid !== 1'b0 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL rstbub got pc=%h v=%b m=%b exp pc=0 v=0 m=0", pc, pc_valid, misalign_err);
    end
    tests++; if (trace_count !== 4'd0 || trace_pc !== 32'h0) begin
      fails++; $display("FAIL rstbub_trace got cnt=%0d tpc=%h exp cnt=0 tpc=0", trace_count, trace_pc);
    end
    rst = 1'b0;
    tick();
    tests++; if (pc !== 32'h0 || pc_valid !== 1'b1 || misalign_err !== 1'b0) begin
      fails++; $display("FAIL rstbub_run got pc=%h v=%b m=%b exp pc=0 v=1 m=0", pc, pc_valid, misalign_err);
    end
  endtask

  initial begin
    rst8 = 1'b1; stall8 = 1'b0; redir8 = 1'b0; trap8 = 1'b0;
    target8 = '0; trace_idx8 = '0;
    test_reset();
    test_startup();
    test_redirect();
    test_stall();
    test_trap_priority();
    test_bubble_redirect();
    test_wrap();
    test_trace();
    test_reset_bubble();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
